// File: rtl/rgb565_ddr_wr_packer_if.sv
// Write-side bus from the RGB565 packer to the DDR3 write FIFO.
// wr_sof and wr_eof qualify wr_data while wr_vld is high.
interface rgb565_ddr_wr_packer_if #(
  parameter int DW = 128
);
  logic [DW-1:0] wr_data;
  logic          wr_vld;
  logic          wr_rdy;
  logic          wr_sof;
  logic          wr_eof;

  modport master (
    output wr_data,
    output wr_vld,
    output wr_sof,
    output wr_eof,
    input  wr_rdy
  );

  modport slave (
    input  wr_data,
    input  wr_vld,
    input  wr_sof,
    input  wr_eof,
    output wr_rdy
  );
endinterface

// File: rtl/rgb565_ddr_wr_packer.sv
// Packs RGB565 pixels into DW-bit words for the DDR3 write FIFO and tracks
// the x/y position within the frame. Frame sync comes from the rising edge of vsync.
module rgb565_ddr_wr_packer #(
  parameter int DW    = 128,
  parameter int H_ACT = 640,
  parameter int V_ACT = 480
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        vsync,
  input  logic [15:0]                 pix_data,
  input  logic                        pix_vld,
  rgb565_ddr_wr_packer_if.master      wr,
  output logic                        frame_done,
  output logic                        ovf
);

  localparam int PIX_PER_WORD = DW / 16;
  localparam int XW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int YW = $clog2(V_ACT + 1);
  localparam int PW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  logic          vs_d;
  logic          armed;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [PW-1:0] pcnt;
  logic [DW-1:0] word_buf;
  logic          word_sof;

  logic          vs_rise;
  logic          accept;
  logic          last_pix;
  logic          at_eol;
  logic          at_eof;
  logic          sof_now;
  logic          can_load;
  logic [DW-1:0] full_word;

  always_comb begin
    vs_rise  = vsync & ~vs_d;
    accept   = armed & pix_vld & ~vs_rise & (y < YW'(V_ACT));
    last_pix = (pcnt == PW'(PIX_PER_WORD - 1));
    at_eol   = (x == XW'(H_ACT - 1));
    at_eof   = at_eol & (y == YW'(V_ACT - 1));
    // The sof flag is latched on the first pixel of a word; on that pixel it comes straight from x/y.
    sof_now  = (pcnt == '0) ? ((x == '0) & (y == '0)) : word_sof;
    can_load = ~wr.wr_vld | wr.wr_rdy;

    full_word = word_buf;
    for (int unsigned k = 0; k < PIX_PER_WORD; k++) begin
      if (pcnt == PW'(k)) full_word[16*k +: 16] = pix_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d       <= 1'b0;
      armed      <= 1'b0;
      x          <= '0;
      y          <= '0;
      pcnt       <= '0;
      word_buf   <= '0;
      word_sof   <= 1'b0;
      wr.wr_data <= '0;
      wr.wr_vld  <= 1'b0;
      wr.wr_sof  <= 1'b0;
      wr.wr_eof  <= 1'b0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      vs_d       <= vsync;
      frame_done <= 1'b0;

      if (wr.wr_vld && wr.wr_rdy) wr.wr_vld <= 1'b0;

      if (vs_rise) begin
        // A pending output word survives the frame boundary; only the partial word is dropped.
        armed    <= 1'b1;
        x        <= '0;
        y        <= '0;
        pcnt     <= '0;
        word_sof <= 1'b0;
      end else if (accept) begin
        word_buf <= full_word;
        word_sof <= sof_now;

        if (at_eol) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end

        if (last_pix) begin
          pcnt       <= '0;
          frame_done <= at_eof;
          if (can_load) begin
            wr.wr_data <= full_word;
            wr.wr_sof  <= sof_now;
            wr.wr_eof  <= at_eof;
            wr.wr_vld  <= 1'b1;
          end else begin
            ovf <= 1'b1;
          end
        end else begin
          pcnt <= pcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb565_ddr_wr_packer.sv
// Directed bench for rgb565_ddr_wr_packer with a 16x2 frame and 128-bit words.
module tb_rgb565_ddr_wr_packer;

  localparam int DW    = 128;
  localparam int H_ACT = 16;
  localparam int V_ACT = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic          sof;
    logic          eof;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic [15:0] pix_data = '0;
  logic        pix_vld = 1'b0;
  logic        frame_done;
  logic        ovf;
  logic        rdy_man = 1'b0;
  logic        tog_en = 1'b0;
  logic        tog = 1'b0;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;
  int q_base = 0;
  word_t got_q[$];
  word_t tbl[12];

  rgb565_ddr_wr_packer_if #(.DW(DW)) wr_if ();

  assign wr_if.wr_rdy = rdy_man | (tog_en & tog);

  rgb565_ddr_wr_packer #(
    .DW   (DW),
    .H_ACT(H_ACT),
    .V_ACT(V_ACT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vsync     (vsync),
    .pix_data  (pix_data),
    .pix_vld   (pix_vld),
    .wr        (wr_if.master),
    .frame_done(frame_done),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tog <= ~tog;

  always @(negedge clk) begin
    if (!rst && wr_if.wr_vld && wr_if.wr_rdy)
      got_q.push_back('{data: wr_if.wr_data, sof: wr_if.wr_sof, eof: wr_if.wr_eof});
    if (!rst && frame_done) fd_cnt++;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [15:0] v);
    pix_vld  = 1'b1;
    pix_data = v;
    tick();
    pix_vld  = 1'b0;
    tick();
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
  endtask

  task automatic mark();
    q_base = got_q.size();
  endtask

  task automatic check_words(input string name, input int start, input int n);
    int got_n;
    got_n = got_q.size() - q_base;
    chk({name, "_count"}, DW'(got_n), DW'(n));
    for (int k = 0; k < n; k++) begin
      if (k < got_n) begin
        chk($sformatf("%s_data%0d", name, k), got_q[q_base+k].data, tbl[start+k].data);
        chk($sformatf("%s_sof%0d", name, k), DW'(got_q[q_base+k].sof), DW'(tbl[start+k].sof));
        chk($sformatf("%s_eof%0d", name, k), DW'(got_q[q_base+k].eof), DW'(tbl[start+k].eof));
      end
    end
  endtask

  initial begin
    int fd0;

    tbl[0]  = '{128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b1, 1'b0};
    tbl[1]  = '{128'h0010_000f_000e_000d_000c_000b_000a_0009, 1'b0, 1'b0};
    tbl[2]  = '{128'h0018_0017_0016_0015_0014_0013_0012_0011, 1'b0, 1'b0};
    tbl[3]  = '{128'h0020_001f_001e_001d_001c_001b_001a_0019, 1'b0, 1'b1};
    tbl[4]  = '{128'h0108_0107_0106_0105_0104_0103_0102_0101, 1'b1, 1'b0};
    tbl[5]  = '{128'h0118_0117_0116_0115_0114_0113_0112_0111, 1'b0, 1'b0};
    tbl[6]  = '{128'h0120_011f_011e_011d_011c_011b_011a_0119, 1'b0, 1'b1};
    tbl[7]  = '{128'h0308_0307_0306_0305_0304_0303_0302_0301, 1'b1, 1'b0};
    tbl[8]  = '{128'h0408_0407_0406_0405_0404_0403_0402_0401, 1'b1, 1'b0};
    tbl[9]  = '{128'h0410_040f_040e_040d_040c_040b_040a_0409, 1'b0, 1'b0};
    tbl[10] = '{128'h0418_0417_0416_0415_0414_0413_0412_0411, 1'b0, 1'b0};
    tbl[11] = '{128'h0420_041f_041e_041d_041c_041b_041a_0419, 1'b0, 1'b1};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_vld", DW'(wr_if.wr_vld), '0);
    chk("rst_sof", DW'(wr_if.wr_sof), '0);
    chk("rst_eof", DW'(wr_if.wr_eof), '0);
    chk("rst_data", wr_if.wr_data, '0);
    chk("rst_ovf", DW'(ovf), '0);
    chk("rst_fd", DW'(frame_done), '0);

    // Unarmed pixels, then a full frame with wr_rdy=1 and latency checks
    rdy_man = 1'b1;
    mark();
    fd0 = fd_cnt;
    for (int i = 0; i < 4; i++) pix(16'hdead);
    repeat (4) tick();
    chk("early_none", DW'(got_q.size() - q_base), '0);
    vs_pulse();
    for (int i = 1; i <= 32; i++) begin
      pix_vld  = 1'b1;
      pix_data = 16'(i);
      tick();
      if (i % 8 == 0) begin
        chk($sformatf("lat_vld_%0d", i), DW'(wr_if.wr_vld), DW'(1));
        chk($sformatf("lat_fd_%0d", i), DW'(frame_done), DW'(i == 32));
      end
      pix_vld = 1'b0;
      tick();
    end
    repeat (4) tick();
    check_words("frameA", 0, 4);
    chk("frameA_fd", DW'(fd_cnt - fd0), DW'(1));
    chk("frameA_ovf", DW'(ovf), '0);

    // Stall across two completions: second word dropped, ovf set
    mark();
    fd0 = fd_cnt;
    rdy_man = 1'b0;
    vs_pulse();
    for (int i = 1; i <= 12; i++) pix(16'h0100 + 16'(i));
    chk("stall_hold12", wr_if.wr_data, tbl[4].data);
    chk("stall_ovf12", DW'(ovf), '0);
    for (int i = 13; i <= 16; i++) pix(16'h0100 + 16'(i));
    chk("stall_hold16", wr_if.wr_data, tbl[4].data);
    chk("stall_sof16", DW'(wr_if.wr_sof), DW'(1));
    chk("stall_vld16", DW'(wr_if.wr_vld), DW'(1));
    chk("stall_ovf16", DW'(ovf), DW'(1));
    rdy_man = 1'b1;
    for (int i = 17; i <= 32; i++) pix(16'h0100 + 16'(i));
    repeat (4) tick();
    check_words("stall", 4, 3);
    chk("stall_fd", DW'(fd_cnt - fd0), DW'(1));
    chk("stall_ovf_sticky", DW'(ovf), DW'(1));

    // Reset mid-frame with a pending word
    rdy_man = 1'b0;
    vs_pulse();
    for (int i = 1; i <= 8; i++) pix(16'h0200 + 16'(i));
    chk("rstmid_pre_vld", DW'(wr_if.wr_vld), DW'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_vld", DW'(wr_if.wr_vld), '0);
    chk("rstmid_ovf", DW'(ovf), '0);
    rdy_man = 1'b1;
    mark();
    for (int i = 1; i <= 8; i++) pix(16'h0250 + 16'(i));
    repeat (4) tick();
    chk("rstmid_none", DW'(got_q.size() - q_base), '0);
    chk("rstmid_vld_after", DW'(wr_if.wr_vld), '0);

    // vsync after 5 pixels with a coincident pixel strobe
    mark();
    vs_pulse();
    for (int i = 1; i <= 5; i++) pix(16'h0200 + 16'(i));
    vsync    = 1'b1;
    pix_vld  = 1'b1;
    pix_data = 16'h02ff;
    tick();
    vsync    = 1'b0;
    pix_vld  = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) pix(16'h0300 + 16'(i));
    repeat (4) tick();
    check_words("vsmid", 7, 1);
    chk("vsmid_ovf", DW'(ovf), '0);

    // wr_rdy toggling every cycle over a full frame
    mark();
    fd0 = fd_cnt;
    rdy_man = 1'b0;
    tog_en  = 1'b1;
    vs_pulse();
    for (int i = 1; i <= 32; i++) pix(16'h0400 + 16'(i));
    repeat (6) tick();
    tog_en = 1'b0;
    check_words("toggle", 8, 4);
    chk("toggle_fd", DW'(fd_cnt - fd0), DW'(1));
    chk("toggle_ovf", DW'(ovf), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
